// File: rtl/riscy_cache_arbiter_if.sv
// ---------------------------------------------------------------------------
// riscy_cache_arbiter_if
//
// Bundles the icache, dcache and memory-side line ports of the cache
// arbiter into one interface.
//
// Signal groups:
//   i_*  icache line-fill port   (read request, address, resp pulse, line data)
//   d_*  dcache fill/writeback   (read/write request, address, write line,
//                                 resp pulse, line data)
//   m_*  memory/L2 port          (read/write strobes, address, write line,
//                                 resp pulse, line data)
//
// Modports:
//   slave  - the arbiter's view: responder to the caches, initiator to memory
//   master - the environment's view: caches plus memory model
// ---------------------------------------------------------------------------
interface riscy_cache_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_resp;
    logic [LINE_WIDTH-1:0] i_rdata256;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata256;
    logic                  d_resp;
    logic [LINE_WIDTH-1:0] d_rdata256;

    logic                  m_read;
    logic                  m_write;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [LINE_WIDTH-1:0] m_wdata256;
    logic                  m_resp;
    logic [LINE_WIDTH-1:0] m_rdata256;

    modport slave (
        input  i_read, i_addr,
        output i_resp, i_rdata256,
        input  d_read, d_write, d_addr, d_wdata256,
        output d_resp, d_rdata256,
        output m_read, m_write, m_addr, m_wdata256,
        input  m_resp, m_rdata256
    );

    modport master (
        output i_read, i_addr,
        input  i_resp, i_rdata256,
        output d_read, d_write, d_addr, d_wdata256,
        input  d_resp, d_rdata256,
        input  m_read, m_write, m_addr, m_wdata256,
        output m_resp, m_rdata256
    );
endinterface

// File: rtl/riscy_cache_arbiter.sv
// ---------------------------------------------------------------------------
// riscy_cache_arbiter
//
// Shares one 256-bit memory/L2 line port between the L1 icache and the
// L1 dcache. One line transaction is in flight at a time: a client is
// granted in IDLE, the memory request is registered onto the m_* port,
// and the transaction ends when memory pulses m_resp, which is forwarded
// combinationally to the granted client as its resp pulse.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - riscy_cache_arbiter_if.slave (icache, dcache and memory ports)
//
// Configuration:
//   ARB_ROUND_ROBIN_EN - when defined, ties in IDLE go to the client that
//                        was not granted last; otherwise dcache always wins.
// ---------------------------------------------------------------------------
module riscy_cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    riscy_cache_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                state;
    logic                  m_read_q;
    logic                  m_write_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [LINE_WIDTH-1:0] m_wdata_q;

    logic                  d_pending;
    logic                  i_pending;
    logic                  grant_d;
    logic                  grant_i;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = dcache was granted last, 0 = icache
    logic                  last_grant_d;
`endif

    assign d_pending = bus.d_read | bus.d_write;
    assign i_pending = bus.i_read;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, dcache wins only if icache had the previous grant.
    assign grant_d = d_pending & (~i_pending | ~last_grant_d);
`else
    assign grant_d = d_pending;
`endif
    assign grant_i = i_pending & ~grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        // A simultaneous read+write is served as a writeback.
                        m_addr_q  <= bus.d_addr;
                        m_write_q <= bus.d_write;
                        m_read_q  <= ~bus.d_write;
                        if (bus.d_write) begin
                            m_wdata_q <= bus.d_wdata256;
                        end
                        state <= SERVE_D;
                    end else if (grant_i) begin
                        m_addr_q  <= bus.i_addr;
                        m_read_q  <= 1'b1;
                        m_write_q <= 1'b0;
                        state     <= SERVE_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // m_* stay frozen until memory completes; requests are ignored.
                    if (bus.m_resp) begin
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d <= (state == SERVE_D);
`endif
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Responses are qualified by state, so m_resp seen in IDLE (including a
    // stale one after a reset) never reaches a client.
    assign bus.i_resp     = (state == SERVE_I) & bus.m_resp;
    assign bus.d_resp     = (state == SERVE_D) & bus.m_resp;
    assign bus.i_rdata256 = bus.m_rdata256;
    assign bus.d_rdata256 = bus.m_rdata256;

    assign bus.m_read     = m_read_q;
    assign bus.m_write    = m_write_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_wdata256 = m_wdata_q;

endmodule

// File: tb/tb_riscy_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscy_cache_arbiter
//
// Directed bench for riscy_cache_arbiter. Stimulus pushes the expected
// memory request and client response of every transaction into queues;
// a monitor thread pops and compares them whenever the DUT starts a
// memory transaction or pulses a client resp.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_riscy_cache_arbiter;

    logic clk;
    logic rst_n;

    riscy_cache_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus();

    riscy_cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic         is_d;
        logic [255:0] data;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    int tests = 0;
    int fails = 0;
    bit tb_last_d = 1'b0;   // model of the last completed grant (1 = dcache)

    task automatic check_w(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records what memory should see and, for completed transactions,
    // which client gets the response and with which line.
    task automatic expect_txn(input logic is_d, input logic wr, input logic [31:0] addr,
                              input logic [255:0] wdata, input logic [255:0] rdata,
                              input bit with_resp);
        mem_exp_t  m;
        resp_exp_t r;
        m.wr = wr; m.addr = addr; m.wdata = wdata;
        mem_q.push_back(m);
        if (with_resp) begin
            r.is_d = is_d; r.data = rdata;
            resp_q.push_back(r);
            tb_last_d = is_d;
        end
    endtask

    function automatic bit tie_winner_d();
`ifdef ARB_ROUND_ROBIN_EN
        return !tb_last_d;
`else
        return 1'b1;
`endif
    endfunction

    // Memory model: waits (bounded) for a request, then answers in the
    // lat-th cycle of the request with the given line.
    task automatic serve(input int lat, input logic [255:0] data);
        bit ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.m_read || bus.m_write) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            check_b("mem_request_timeout", 1'b0, 1'b1);
        end else begin
            for (int k = 1; k < lat; k++) tick();
            bus.m_resp     = 1'b1;
            bus.m_rdata256 = data;
            tick();
            bus.m_resp     = 1'b0;
            bus.m_rdata256 = ~data;
        end
    endtask

    task automatic monitor();
        bit           prev_act = 1'b0;
        bit           unstable = 1'b0;
        logic         act;
        logic         lat_r, lat_w;
        logic [31:0]  lat_a;
        logic [255:0] lat_wd;
        mem_exp_t     m;
        resp_exp_t    r;
        forever begin
            @(negedge clk);
            act = bus.m_read | bus.m_write;
            if (act && !prev_act) begin
                if (mem_q.size() == 0) begin
                    check_b("unexpected_mem_request", 1'b1, 1'b0);
                end else begin
                    m = mem_q.pop_front();
                    check_b("mem_write", bus.m_write, m.wr);
                    check_b("mem_read", bus.m_read, !m.wr);
                    check_w("mem_addr", 256'(bus.m_addr), 256'(m.addr));
                    if (m.wr) check_w("mem_wdata", bus.m_wdata256, m.wdata);
                end
                lat_r = bus.m_read; lat_w = bus.m_write;
                lat_a = bus.m_addr; lat_wd = bus.m_wdata256;
                unstable = 1'b0;
            end else if (act) begin
                if (bus.m_read !== lat_r || bus.m_write !== lat_w ||
                    bus.m_addr !== lat_a || bus.m_wdata256 !== lat_wd)
                    unstable = 1'b1;
            end else if (prev_act) begin
                check_b("mem_stable", unstable, 1'b0);
            end
            prev_act = act;

            if (bus.i_resp || bus.d_resp) begin
                if (bus.i_resp && bus.d_resp) check_b("both_resp", 1'b1, 1'b0);
                if (resp_q.size() == 0) begin
                    check_b("unexpected_resp", 1'b1, 1'b0);
                end else begin
                    r = resp_q.pop_front();
                    check_b("resp_client_d", bus.d_resp, r.is_d);
                    check_w("resp_data", bus.d_resp ? bus.d_rdata256 : bus.i_rdata256, r.data);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] a5, wd, wd2, dd, di;
        bit           first_d;
        bit           win;

        a5  = {32{8'hA5}};
        wd  = {8{32'h1234_5678}};
        wd2 = {8{32'hDEAD_BEEF}};

        rst_n = 1'b0;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata256 = '0;
        bus.m_resp = 1'b0; bus.m_rdata256 = '0;

        fork
            monitor();
        join_none

        // Reset state, with a stray m_resp that must not leak through
        tick();
        bus.m_resp = 1'b1;
        #2;
        check_b("rst_m_read", bus.m_read, 1'b0);
        check_b("rst_m_write", bus.m_write, 1'b0);
        check_w("rst_m_addr", 256'(bus.m_addr), 256'd0);
        check_w("rst_m_wdata", bus.m_wdata256, 256'd0);
        check_b("rst_i_resp", bus.i_resp, 1'b0);
        check_b("rst_d_resp", bus.d_resp, 1'b0);
        tick();
        bus.m_resp = 1'b0;
        rst_n = 1'b1;
        tick();

        // icache read, memory answers in 3rd cycle
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_1000;
        expect_txn(1'b0, 1'b0, 32'h0000_1000, '0, a5, 1'b1);
        tick();
        check_b("i_lat_m_read", bus.m_read, 1'b1);
        check_w("i_lat_m_addr", 256'(bus.m_addr), 256'h1000);
        serve(3, a5);
        bus.i_read = 1'b0;
        check_b("i_m_read_clear", bus.m_read, 1'b0);
        tick();

        // dcache writeback, memory answers in 5th cycle
        bus.d_write = 1'b1; bus.d_addr = 32'h0000_2040; bus.d_wdata256 = wd;
        expect_txn(1'b1, 1'b1, 32'h0000_2040, wd, 256'h55, 1'b1);
        tick();
        check_b("d_lat_m_write", bus.m_write, 1'b1);
        serve(5, 256'h55);
        bus.d_write = 1'b0;
        check_b("d_m_write_clear", bus.m_write, 1'b0);
        tick();

        // Simultaneous dcache read+write is served as a write
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h0000_2080; bus.d_wdata256 = wd2;
        expect_txn(1'b1, 1'b1, 32'h0000_2080, wd2, 256'h77, 1'b1);
        tick();
        serve(2, 256'h77);
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        tick();

        // Tie between icache and dcache reads
        dd = {8{32'hD0D0_0001}};
        di = {8{32'h1C1C_0001}};
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_3000;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_4000;
        first_d = tie_winner_d();
        if (first_d) begin
            expect_txn(1'b1, 1'b0, 32'h0000_4000, '0, dd, 1'b1);
            expect_txn(1'b0, 1'b0, 32'h0000_3000, '0, di, 1'b1);
        end else begin
            expect_txn(1'b0, 1'b0, 32'h0000_3000, '0, di, 1'b1);
            expect_txn(1'b1, 1'b0, 32'h0000_4000, '0, dd, 1'b1);
        end
        tick();
        serve(2, first_d ? dd : di);
        if (first_d) bus.d_read = 1'b0; else bus.i_read = 1'b0;
        check_b("tie_idle_gap", bus.m_read, 1'b0);
        serve(2, first_d ? di : dd);
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        tick();

        // Lone dcache read so the last grant is dcache
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_6000;
        expect_txn(1'b1, 1'b0, 32'h0000_6000, '0, 256'h66, 1'b1);
        tick();
        serve(2, 256'h66);
        bus.d_read = 1'b0;
        tick();

        // Both clients held across four consecutive ties
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_5000;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_6000;
        for (int k = 0; k < 4; k++) begin
            win = tie_winner_d();
            expect_txn(win, 1'b0, win ? 32'h0000_6000 : 32'h0000_5000, '0,
                       {8{32'hC0DE_0000 + 32'(k)}}, 1'b1);
        end
        tick();
        for (int k = 0; k < 4; k++) serve(2, {8{32'hC0DE_0000 + 32'(k)}});
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        tick();

        // m_resp while idle produces no client response
        bus.m_resp = 1'b1; bus.m_rdata256 = {256{1'b1}};
        #3;
        check_b("idle_mresp_i", bus.i_resp, 1'b0);
        check_b("idle_mresp_d", bus.d_resp, 1'b0);
        tick();
        bus.m_resp = 1'b0;
        tick();

        // Reset in the middle of a dcache read, then a stale m_resp
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_7000;
        expect_txn(1'b1, 1'b0, 32'h0000_7000, '0, '0, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        tb_last_d = 1'b0;
        #1;
        check_b("async_rst_m_read", bus.m_read, 1'b0);
        check_w("async_rst_m_addr", 256'(bus.m_addr), 256'd0);
        bus.d_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.m_resp = 1'b1; bus.m_rdata256 = a5;
        #3;
        check_b("stale_mresp_d", bus.d_resp, 1'b0);
        check_b("stale_mresp_i", bus.i_resp, 1'b0);
        tick();
        bus.m_resp = 1'b0;
        tick();
        tick();

        check_w("mem_queue_drained", 256'(mem_q.size()), 256'd0);
        check_w("resp_queue_drained", 256'(resp_q.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
